// File: rtl/sprite_ram_scheduler.sv
// Sprite-sheet frame RAM port scheduler.
// Shares the single RAM port between the pixel read path (priority during
// active video) and a loader write FIFO that drains only during blanking.
// Optional feature macro: SPRITE_RAM_SCHED_OVF_EN builds the sticky overflow
// flag on ld_ovf; when undefined ld_ovf is tied low.
module sprite_ram_scheduler #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 4
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              blank_n,
  input  logic [ADDR_W-1:0] pix_addr,
  output logic [DATA_W-1:0] pix_data,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  input  logic              ld_flush,
  output logic              ld_flush_ack,
  output logic              ld_ovf,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    StActive,
    StDrain,
    StHold
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] addr_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] data_mem [FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             flush_pend_q, flush_pend_d;
  logic             rd_ok_q;
  logic             push;
  logic             pop;
  logic             fifo_empty;

  // FIFO handshake, pop condition and flush acknowledge
  always_comb begin
    fifo_empty   = (count_q == '0);
    ld_ready     = (count_q < FULL_CNT);
    push         = ld_valid && ld_ready;
    pop          = !blank_n && !fifo_empty;
    ld_flush_ack = flush_pend_q && fifo_empty && !push;
    flush_pend_d = ld_flush || (flush_pend_q && !ld_flush_ack);
  end

  // FIFO pointer and occupancy next-state; pointers wrap naturally at FIFO_DEPTH
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FSM next state and RAM port mux; the mux follows the live blank_n
  always_comb begin
    state_d   = StActive;
    ram_addr  = pix_addr;
    ram_wdata = '0;
    ram_we    = 1'b0;
    if (!blank_n) begin
      state_d = fifo_empty ? StHold : StDrain;
    end
    if (pop) begin
      ram_addr  = addr_mem[rd_ptr_q];
      ram_wdata = data_mem[rd_ptr_q];
      ram_we    = 1'b1;
    end
  end

  // StDrain in state_q means last cycle was a write, so read data is stale
  always_comb begin
    pix_data = (rd_ok_q && (state_q != StDrain)) ? ram_rdata : '0;
  end

  // State, pointers, count and flush bookkeeping
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= StActive;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      flush_pend_q <= 1'b0;
      rd_ok_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      flush_pend_q <= flush_pend_d;
      rd_ok_q      <= 1'b1;
    end
  end

  // FIFO storage; contents are don't-care while count is zero
  always_ff @(posedge Clk) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= ld_addr;
      data_mem[wr_ptr_q] <= ld_data;
    end
  end

`ifdef SPRITE_RAM_SCHED_OVF_EN
  logic ovf_q;

  // Sticky overflow: a request presented while the FIFO is full
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ovf_q <= 1'b0;
    end else if (ld_valid && !ld_ready) begin
      ovf_q <= 1'b1;
    end
  end

  assign ld_ovf = ovf_q;
`else
  assign ld_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_ram_scheduler.sv
// Directed self-checking bench for sprite_ram_scheduler with a behavioural
// frame RAM preloaded so that mem[a] = a[3:0].
module tb_sprite_ram_scheduler;

`ifdef SPRITE_RAM_SCHED_OVF_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  logic        Clk;
  logic        Reset_n;
  logic        blank_n;
  logic [15:0] pix_addr;
  logic [3:0]  pix_data;
  logic        ld_valid;
  logic [15:0] ld_addr;
  logic [3:0]  ld_data;
  logic        ld_ready;
  logic        ld_flush;
  logic        ld_flush_ack;
  logic        ld_ovf;
  logic [15:0] ram_addr;
  logic [3:0]  ram_wdata;
  logic        ram_we;
  logic [3:0]  ram_rdata;

  logic [3:0]  ram_mem [65536];

  int n_chk  = 0;
  int n_fail = 0;

  sprite_ram_scheduler #(
    .FIFO_DEPTH(8),
    .ADDR_W    (16),
    .DATA_W    (4)
  ) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .blank_n     (blank_n),
    .pix_addr    (pix_addr),
    .pix_data    (pix_data),
    .ld_valid    (ld_valid),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .ld_ready    (ld_ready),
    .ld_flush    (ld_flush),
    .ld_flush_ack(ld_flush_ack),
    .ld_ovf      (ld_ovf),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_we      (ram_we),
    .ram_rdata   (ram_rdata)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Synchronous single-port RAM, read-before-write, 1-cycle read latency
  always @(posedge Clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    ram_rdata <= ram_mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge, away from the active edge
  task automatic step_cycle();
    @(negedge Clk);
  endtask

  task automatic expect_wr(input string tag, input logic [15:0] a, input logic [3:0] d);
    check({tag, "_we"}, 32'(ram_we), 32'd1);
    check({tag, "_addr"}, 32'(ram_addr), 32'(a));
    check({tag, "_wdata"}, 32'(ram_wdata), 32'(d));
  endtask

  task automatic expect_rd(input string tag, input logic [15:0] a);
    check({tag, "_we"}, 32'(ram_we), 32'd0);
    check({tag, "_addr"}, 32'(ram_addr), 32'(a));
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      ram_mem[i] = 4'(i);
    end
    Reset_n  = 1'b0;
    blank_n  = 1'b1;
    pix_addr = '0;
    ld_valid = 1'b0;
    ld_addr  = '0;
    ld_data  = '0;
    ld_flush = 1'b0;
    #1;
    check("rst_ready", 32'(ld_ready), 32'd1);
    check("rst_pix", 32'(pix_data), 32'd0);
    check("rst_wdata", 32'(ram_wdata), 32'd0);
    check("rst_ack", 32'(ld_flush_ack), 32'd0);
    check("rst_ovf", 32'(ld_ovf), 32'd0);
    check("rst_we", 32'(ram_we), 32'd0);

    step_cycle();
    Reset_n = 1'b1;

    // Active video sweep with three loader pushes queued along the way
    for (int a = 0; a < 40; a++) begin
      step_cycle();
      pix_addr = 16'(a);
      ld_valid = (a >= 5) && (a <= 7);
      ld_addr  = 16'h0100 + 16'(a - 5);
      ld_data  = (a == 5) ? 4'h3 : (a == 6) ? 4'h7 : 4'hB;
      #1;
      expect_rd("sweep", 16'(a));
      if (a > 0) check("sweep_pix", 32'(pix_data), 32'((a - 1) & 15));
      if (ld_valid) check("sweep_ready", 32'(ld_ready), 32'd1);
    end

    // Blanking drains the three writes in order, then holds
    step_cycle();
    ld_valid = 1'b0;
    blank_n  = 1'b0;
    #1;
    check("drain_pix39", 32'(pix_data), 32'd7);
    expect_wr("drain0", 16'h0100, 4'h3);
    step_cycle();
    #1;
    expect_wr("drain1", 16'h0101, 4'h7);
    check("drain_pix_sky", 32'(pix_data), 32'd0);
    step_cycle();
    #1;
    expect_wr("drain2", 16'h0102, 4'hB);
    step_cycle();
    pix_addr = 16'h0100;
    #1;
    expect_rd("hold0", 16'h0100);
    check("hold_pix_sky", 32'(pix_data), 32'd0);
    step_cycle();
    pix_addr = 16'h0101;
    #1;
    check("readback0", 32'(pix_data), 32'h3);
    step_cycle();
    pix_addr = 16'h0102;
    #1;
    check("readback1", 32'(pix_data), 32'h7);
    step_cycle();
    #1;
    check("readback2", 32'(pix_data), 32'hB);

    // Fill the FIFO during active video; ninth push is refused
    for (int i = 0; i < 9; i++) begin
      step_cycle();
      blank_n  = 1'b1;
      ld_valid = 1'b1;
      ld_addr  = 16'h0200 + 16'(i);
      ld_data  = 4'(i + 1);
      #1;
      check("fill_ready", 32'(ld_ready), 32'(i < 8));
    end
    step_cycle();
    ld_valid = 1'b0;
    #1;
    check("full_ready", 32'(ld_ready), 32'd0);
    check("full_ovf", 32'(ld_ovf), 32'(OVF_EXP));

    // One pop to count 7, then push+pop at count 7 keeps it at 7
    step_cycle();
    blank_n = 1'b0;
    #1;
    expect_wr("pp_pop", 16'h0200, 4'h1);
    step_cycle();
    ld_valid = 1'b1;
    ld_addr  = 16'h0208;
    ld_data  = 4'h9;
    #1;
    check("pp_ready", 32'(ld_ready), 32'd1);
    expect_wr("pp_both", 16'h0201, 4'h2);
    step_cycle();
    blank_n  = 1'b1;
    pix_addr = 16'h0055;
    ld_addr  = 16'h0209;
    ld_data  = 4'hA;
    #1;
    check("pp_ready7", 32'(ld_ready), 32'd1);
    expect_rd("pp_active", 16'h0055);
    step_cycle();
    ld_valid = 1'b0;
    #1;
    check("pp_full", 32'(ld_ready), 32'd0);

    // Blanking lasts two cycles: two writes, then a read-only active cycle
    step_cycle();
    blank_n = 1'b0;
    #1;
    expect_wr("mid0", 16'h0202, 4'h3);
    step_cycle();
    #1;
    expect_wr("mid1", 16'h0203, 4'h4);
    step_cycle();
    blank_n  = 1'b1;
    pix_addr = 16'h1234;
    #1;
    expect_rd("mid_active", 16'h1234);
    check("mid_ready", 32'(ld_ready), 32'd1);
    step_cycle();
    blank_n = 1'b0;
    for (int j = 0; j < 6; j++) begin
      if (j > 0) step_cycle();
      #1;
      expect_wr("rest", 16'h0204 + 16'(j), 4'(5 + j));
    end
    step_cycle();
    #1;
    expect_rd("rest_hold", 16'h1234);

    // Flush with two queued: ack one cycle after the second write
    step_cycle();
    blank_n  = 1'b1;
    ld_valid = 1'b1;
    ld_addr  = 16'h0300;
    ld_data  = 4'hC;
    step_cycle();
    ld_addr  = 16'h0301;
    ld_data  = 4'hD;
    step_cycle();
    ld_valid = 1'b0;
    ld_flush = 1'b1;
    #1;
    check("fl_ack_req", 32'(ld_flush_ack), 32'd0);
    step_cycle();
    ld_flush = 1'b0;
    #1;
    check("fl_ack_pend", 32'(ld_flush_ack), 32'd0);
    step_cycle();
    blank_n = 1'b0;
    #1;
    expect_wr("fl_w0", 16'h0300, 4'hC);
    check("fl_ack_w0", 32'(ld_flush_ack), 32'd0);
    step_cycle();
    #1;
    expect_wr("fl_w1", 16'h0301, 4'hD);
    check("fl_ack_w1", 32'(ld_flush_ack), 32'd0);
    step_cycle();
    #1;
    check("fl_we_done", 32'(ram_we), 32'd0);
    check("fl_ack", 32'(ld_flush_ack), 32'd1);
    step_cycle();
    #1;
    check("fl_ack_once", 32'(ld_flush_ack), 32'd0);

    // Flush on an empty FIFO acks the next cycle
    step_cycle();
    ld_flush = 1'b1;
    #1;
    check("fe_ack_req", 32'(ld_flush_ack), 32'd0);
    step_cycle();
    ld_flush = 1'b0;
    #1;
    check("fe_ack", 32'(ld_flush_ack), 32'd1);
    step_cycle();
    #1;
    check("fe_ack_once", 32'(ld_flush_ack), 32'd0);

    // Reset mid-drain with five queued discards the remainder
    for (int i = 0; i < 5; i++) begin
      step_cycle();
      blank_n  = 1'b1;
      ld_valid = 1'b1;
      ld_addr  = 16'h0400 + 16'(i);
      ld_data  = 4'h5;
    end
    step_cycle();
    ld_valid = 1'b0;
    blank_n  = 1'b0;
    #1;
    expect_wr("rd_w0", 16'h0400, 4'h5);
    step_cycle();
    Reset_n = 1'b0;
    #1;
    check("mrst_ready", 32'(ld_ready), 32'd1);
    check("mrst_we", 32'(ram_we), 32'd0);
    check("mrst_pix", 32'(pix_data), 32'd0);
    check("mrst_wdata", 32'(ram_wdata), 32'd0);
    check("mrst_ack", 32'(ld_flush_ack), 32'd0);
    check("mrst_ovf", 32'(ld_ovf), 32'd0);
    step_cycle();
    Reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("post_rst_we", 32'(ram_we), 32'd0);
      step_cycle();
    end
    check("ram_0400", 32'(ram_mem[16'h0400]), 32'h5);
    check("ram_0401", 32'(ram_mem[16'h0401]), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
